// File: rtl/led_pattern_gen_pkg.sv
// led_pkg: shared types and helpers for the LED pattern generator
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN_UP,
        MODE_BIN_DOWN,
        MODE_GRAY,
        MODE_SCAN
    } mode_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    function automatic logic [31:0] gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic int div_width(input int div);
        return (div >= 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_if: control inputs and LED/status outputs of the pattern generator
interface led_if #(
    parameter int N_LED = 6
);
    logic             en_i;
    logic             step_i;
    logic [1:0]       mode_i;
    logic [N_LED-1:0] led_o;
    logic             tick_o;
    logic [1:0]       mode_o;

    modport master (output en_i, step_i, mode_i, input led_o, tick_o, mode_o);
    modport slave  (input en_i, step_i, mode_i, output led_o, tick_o, mode_o);
endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// tick_gen: prescaler producing one tick every DIV cycles while enabled
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int W = div_width(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: DIV must be at least 2");
    end

    logic [W-1:0] pre;

    assign tick_o = en_i && !rst_i && (pre == W'(DIV - 1));

    // Count while enabled; pausing or wrapping returns to zero so each run starts a full period
    always_ff @(posedge clk) begin
        pre <= (rst_i || !en_i || tick_o) ? '0 : pre + W'(1);
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with four selectable patterns
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int STEP_HZ    = 2,
    parameter int N_LED      = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic rst_i,
    led_if.slave bus
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = $clog2(N_LED);

    if (N_LED < 2 || N_LED > 32) begin : g_bad_n
        $error("led_pattern_gen: N_LED must be in 2..32");
    end

    mode_t            mode_q, mode_n, mode_req;
    dir_t             dir, dir_n;
    logic [N_LED-1:0] cnt, cnt_n, pat;
    logic [PW-1:0]    pos, pos_n;
    logic             tick, adv;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_i  (rst_i),
        .en_i   (bus.en_i),
        .tick_o (tick)
    );

    assign adv      = tick | (bus.step_i & ~bus.en_i);
    assign mode_req = mode_t'(bus.mode_i);

    // Pattern state register; reset adopts the requested mode directly
    always_ff @(posedge clk) begin
        if (rst_i) begin
            mode_q <= mode_req;
            cnt    <= '0;
            pos    <= '0;
            dir    <= DIR_UP;
        end else begin
            mode_q <= mode_n;
            cnt    <= cnt_n;
            pos    <= pos_n;
            dir    <= dir_n;
        end
    end

    // Advance: a mode change loads the init state, otherwise step counter and scanner
    always_comb begin
        mode_n = mode_q;
        cnt_n  = cnt;
        pos_n  = pos;
        dir_n  = dir;
        if (adv && mode_req != mode_q) begin
            mode_n = mode_req;
            cnt_n  = '0;
            pos_n  = '0;
            dir_n  = DIR_UP;
        end else if (adv) begin
            cnt_n = (mode_q == MODE_BIN_DOWN) ? cnt - N_LED'(1) : cnt + N_LED'(1);
            pos_n = (dir == DIR_UP) ? pos + PW'(1) : pos - PW'(1);
            dir_n = (dir == DIR_UP) ? ((pos == PW'(N_LED - 2)) ? DIR_DOWN : DIR_UP)
                                    : ((pos == PW'(1)) ? DIR_UP : DIR_DOWN);
        end
    end

    // Output mapping straight from registers, polarity applied last
    always_comb begin
        pat = (mode_q == MODE_SCAN) ? (N_LED'(1) << pos)
            : (mode_q == MODE_GRAY) ? N_LED'(gray(32'(cnt)))
            : cnt;
    end

    assign bus.led_o  = ACTIVE_LOW ? ~pat : pat;
    assign bus.tick_o = tick;
    assign bus.mode_o = mode_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench driving an active-high and an active-low instance
module tb_led_pattern_gen;

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic [1:0] mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_d = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t pe, e;
    bit   pend = 1'b0;

    led_if #(.N_LED(4)) bus0 ();
    led_if #(.N_LED(4)) bus1 ();

    assign bus1.en_i   = bus0.en_i;
    assign bus1.step_i = bus0.step_i;
    assign bus1.mode_i = bus0.mode_i;

    led_pattern_gen #(.CLK_HZ(10), .STEP_HZ(2), .N_LED(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    led_pattern_gen #(.CLK_HZ(10), .STEP_HZ(2), .N_LED(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic check_out(input exp_t x);
        logic [3:0] inv;
        inv = ~x.led;
        chk("led_o", int'(bus0.led_o), int'(x.led));
        chk("led_o_active_low", int'(bus1.led_o), int'(inv));
        chk("mode_o", int'(bus0.mode_o), int'(x.mode));
    endtask

    // Monitor: reset events are checked at once, advances are timed now and checked next cycle
    always @(negedge clk) begin
        if (rst_d) begin
            pend = 1'b0;
            if (q.size() == 0) chk("unexpected_reset", 1, 0);
            else begin
                e = q.pop_front();
                chk("reset_cycle", cyc, e.cyc);
                check_out(e);
            end
        end else begin
            if (pend) begin
                check_out(pe);
                pend = 1'b0;
            end
            if (!rst && (bus0.tick_o || (bus0.step_i && !bus0.en_i))) begin
                if (q.size() == 0) chk("unexpected_advance", cyc, -1);
                else begin
                    pe = q.pop_front();
                    chk("advance_cycle", cyc, pe.cyc);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] l, input logic [1:0] m);
        exp_t x;
        x.cyc  = c;
        x.led  = l;
        x.mode = m;
        q.push_back(x);
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic en);
        rst         = 1'b1;
        bus0.mode_i = m;
        bus0.en_i   = en;
        bus0.step_i = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push(base, (m == 2'd3) ? 4'b0001 : 4'b0000, m);
    endtask

    initial begin
        logic [3:0] gray_seq[8];
        logic [3:0] scan_seq[7];
        gray_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        scan_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bus0.en_i   = 1'b0;
        bus0.step_i = 1'b0;
        bus0.mode_i = 2'd0;
        // binary up: ticks every 5 cycles starting at cycle 4, wrapping after 16 steps
        do_reset(2'd0, 1'b1);
        for (int k = 1; k <= 16; k++) push(base + 5 * k - 1, 4'(k), 2'd0);
        to_cycle(base + 81);
        // binary down from zero wraps to all ones
        do_reset(2'd1, 1'b1);
        push(base + 4, 4'b1111, 2'd1);
        push(base + 9, 4'b1110, 2'd1);
        push(base + 14, 4'b1101, 2'd1);
        to_cycle(base + 16);
        // gray code sequence
        do_reset(2'd2, 1'b1);
        for (int k = 0; k < 8; k++) push(base + 5 * k + 4, gray_seq[k], 2'd2);
        to_cycle(base + 41);
        // scanner bounce, then a mid-period mode change taking effect on the next tick
        do_reset(2'd3, 1'b1);
        for (int k = 0; k < 7; k++) push(base + 5 * k + 4, scan_seq[k], 2'd3);
        to_cycle(base + 37);
        bus0.mode_i = 2'd0;
        push(base + 39, 4'b0000, 2'd0);
        push(base + 44, 4'b0001, 2'd0);
        to_cycle(base + 46);
        // pause with pre = 3, single steps, held step, re-enable, ignored step, en drop at pre = 4
        do_reset(2'd0, 1'b1);
        push(base + 4, 4'd1, 2'd0);
        to_cycle(base + 8);
        bus0.en_i = 1'b0;
        to_cycle(base + 9);
        bus0.step_i = 1'b1;
        push(base + 9, 4'd2, 2'd0);
        to_cycle(base + 10);
        bus0.step_i = 1'b0;
        to_cycle(base + 11);
        bus0.step_i = 1'b1;
        push(base + 11, 4'd3, 2'd0);
        to_cycle(base + 12);
        bus0.step_i = 1'b0;
        to_cycle(base + 13);
        bus0.step_i = 1'b1;
        push(base + 13, 4'd4, 2'd0);
        to_cycle(base + 14);
        bus0.step_i = 1'b0;
        to_cycle(base + 15);
        bus0.step_i = 1'b1;
        push(base + 15, 4'd5, 2'd0);
        push(base + 16, 4'd6, 2'd0);
        to_cycle(base + 17);
        bus0.step_i = 1'b0;
        to_cycle(base + 18);
        bus0.en_i = 1'b1;
        push(base + 22, 4'd7, 2'd0);
        to_cycle(base + 24);
        bus0.step_i = 1'b1;
        to_cycle(base + 26);
        bus0.step_i = 1'b0;
        push(base + 27, 4'd8, 2'd0);
        to_cycle(base + 32);
        bus0.en_i = 1'b0;
        to_cycle(base + 40);
        // reset in the middle of a gray run discards the partial count
        do_reset(2'd2, 1'b1);
        push(base + 4, 4'b0001, 2'd2);
        push(base + 9, 4'b0011, 2'd2);
        to_cycle(base + 12);
        do_reset(2'd2, 1'b1);
        push(base + 4, 4'b0001, 2'd2);
        to_cycle(base + 8);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for the Tang Nano 9K user LEDs; the successor to the fixed 6-bit binary blink counter. A prescaler derives a step rate from the board clock. Each step advances one of four selectable patterns: binary up, binary down, Gray code, or bouncing scanner. It adds run/pause, single-step, and configurable LED polarity, and it sits directly between the board clock/button inputs and the LED pins.

## Interface
- CLK_HZ, 27_000_000, input clock frequency.
- STEP_HZ, 2, pattern advance rate; DIV = CLK_HZ/STEP_HZ, integer, DIV ≥ 2 (elaboration error otherwise).
- N_LED, 6, number of LEDs; 2..32.
- ACTIVE_LOW, 1, 1: led_o is inverted (LED lit = 0), matching the 9K board.
- clk  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high; dominates all other inputs.
- en_i  in  1  run enable; 1 = free-running advance, 0 = paused.
- step_i  in  1  single-cycle pulse; advances the pattern once while en_i = 0.
- mode_i  in  2  requested mode: 0 BIN_UP, 1 BIN_DOWN, 2 GRAY, 3 SCAN.
- led_o  out  N_LED  LED drive (polarity per ACTIVE_LOW).
- tick_o  out  1  high for the one cycle in which a prescaler advance occurs.
- mode_o  out  2  currently active mode (mode_q).

## Operation
- Prescaler pre: counts 0..DIV-1 while en_i = 1; at DIV-1 it wraps to 0 and tick_o = 1 (combinational: en_i & pre==DIV-1). Period is exactly DIV cycles.
- en_i = 0: pre is cleared and held at 0 and tick_o = 0. On re-enable, a full DIV period elapses before the next tick.
- Advance event adv = tick_o | (step_i & ~en_i). step_i is ignored while en_i = 1. A step_i held high for k cycles while paused gives k advances.
- On adv with mode_i ≠ mode_q: mode_q ← mode_i and the state loads the init value (cnt = 0, pos = 0, dir = up). This is the first pattern of the new mode; there is no step.
- On adv with mode_i = mode_q, step per mode:
  - BIN_UP: cnt ← cnt+1 mod 2^N_LED.
  - BIN_DOWN: cnt ← cnt-1 mod 2^N_LED; 0 → all ones.
  - GRAY: cnt ← cnt+1 mod 2^N_LED; pattern = cnt ^ (cnt >> 1).
  - SCAN: if dir = up, pos+1, reversing to down when it reaches N_LED-1. If dir = down, pos-1, reversing to up at 0. Pattern is one-hot at bit pos. Sequence for N_LED = 4: 0,1,2,3,2,1,0,1…; period 2(N_LED-1). There is no dwell at the ends.
- Pattern: cnt for BIN modes, Gray(cnt) for GRAY, 1 << pos for SCAN. led_o = ACTIVE_LOW ? ~pattern : pattern.
- Reset (rst_i = 1 at an edge): pre = 0, cnt = 0, pos = 0, dir = up, mode_q ← mode_i. After reset, led_o = pattern of the init state (all off, or bit 0 lit in SCAN), polarity-adjusted. tick_o = 0 while rst_i is high.

## Timing
- State registers update on the clk edge ending the adv cycle. led_o reflects the new state from the next cycle on; it is combinational from registers, with no extra pipeline stage.
- With en_i = 1 constant after reset: first tick_o in cycle DIV-1 (counting from 0 after reset release); first led change visible at cycle DIV.
- mode_i is sampled only on adv. Changes between adv events have no effect on led_o or mode_o.
- Reset mid-period discards the partial count. The next tick comes DIV cycles after release.
- en_i falling in the same cycle that pre = DIV-1: no tick, because en_i gates tick_o.

## Structure
- Package led_pkg holds:
  - the mode_t enum (MODE_BIN_UP, MODE_BIN_DOWN, MODE_GRAY, MODE_SCAN);
  - the gray() function;
  - the DIV/width derivation helper ($clog2(DIV)).
- Sub-module tick_gen (params DIV; ports clk, rst_i, en_i, tick_o) holds the prescaler. The pattern state machine and the output mapping live in the top block.

## Test plan
All scenarios use CLK_HZ = 10, STEP_HZ = 2 (DIV = 5), N_LED = 4, ACTIVE_LOW = 0 unless noted.
- Reset, en_i = 1, mode 0 for 20 cycles → tick_o in cycles 4, 9, 14, 19; led_o = 0, 1, 2, 3 changing at cycles 5, 10, 15.
- mode 1 from reset, en_i = 1 → first step gives led_o = 4'b1111, then 1110. Mode 0 run 16 ticks → wraps 1111 → 0000.
- mode 2, 8 ticks → led_o sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
- mode 3, 7 ticks → bit positions 0, 1, 2, 3, 2, 1, 0, 1. Change mode_i to 0 mid-period → led_o unchanged until the next tick, then 0000, mode_o = 0.
- en_i = 0 with pre = 3, three step_i pulses → led_o +3, tick_o stays 0. Re-enable → next tick exactly 5 cycles later. step_i with en_i = 1 → no extra advance.
- ACTIVE_LOW = 1: reset → led_o = 4'b1111. Assert rst_i mid-count in mode 2 → all state cleared on the next edge, first tick 5 cycles after release.
